drop_timer: RTL

- Consumer end of the gravity tick path.
- Takes the 1-cycle `tick_in` pulses from the half-second tick generator and counts them against a level-dependent interval.
- Also runs a fast cycle counter for soft-drop.
- Issues drop requests to the game-control FSM over a req/ack handshake and flags drops lost to a slow consumer.

---
 rtl/drop_timer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/drop_timer.sv
// drop_timer: consumer end of the gravity tick path.
// Counts tick_in pulses against a level-dependent interval, runs a fast
// cycle counter for soft-drop, and hands one-row drop requests to the
// game-control FSM over a req/ack handshake. A drop that falls due while a
// request is still pending is discarded and reported on overrun.
module drop_timer #(
  parameter int BASE_TICKS  = 4,
  parameter int MIN_TICKS   = 1,
  parameter int SOFT_CYCLES = 5000000
) (
  input  logic       clk100m,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       enable,
  input  logic [3:0] level,
  input  logic       soft_drop,
  input  logic       restart,
  output logic       drop_req,
  input  logic       drop_ack,
  output logic       overrun
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_REQ   = 2'd2
  } state_e;

  localparam logic signed [4:0] BASE_S    = 5'(BASE_TICKS);
  localparam logic signed [4:0] MIN_S     = 5'(MIN_TICKS);
  localparam logic [22:0]       SOFT_LAST = 23'(SOFT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [22:0] soft_cnt_q, soft_cnt_d;
  logic        drop_req_q, drop_req_d;
  logic        overrun_q, overrun_d;

  logic signed [4:0] n_raw_s;
  logic signed [4:0] n_s;
  logic [4:0]        n_u_s;
  logic [4:0]        tick_next_s;
  logic              tick_due_s;
  logic              soft_due_s;
  logic              due_s;

  // Interval and due detection; signed so high levels clamp to the floor.
  always_comb begin
    n_raw_s = BASE_S - $signed({1'b0, level});
    if (n_raw_s < MIN_S) begin
      n_s = MIN_S;
    end else begin
      n_s = n_raw_s;
    end
    n_u_s       = n_s;
    tick_next_s = {1'b0, tick_cnt_q} + 5'd1;
    // >= (not ==) so a level raise past the current count fires on the next tick
    tick_due_s  = tick_in & (tick_next_s >= n_u_s);
    soft_due_s  = soft_drop & (soft_cnt_q == SOFT_LAST);
    due_s       = tick_due_s | soft_due_s;
  end

  // Next-state, counter and output computation.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    soft_cnt_d = soft_cnt_q;
    drop_req_d = drop_req_q;
    overrun_d  = 1'b0;
    if (!enable) begin
      // parked: also withdraws any pending request
      state_d    = ST_IDLE;
      tick_cnt_d = 4'd0;
      soft_cnt_d = 23'd0;
      drop_req_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_COUNT;
          tick_cnt_d = 4'd0;
          soft_cnt_d = 23'd0;
          drop_req_d = 1'b0;
        end
        ST_COUNT, ST_REQ: begin
          if (restart) begin
            // new piece: forget accumulated time and any pending request
            state_d    = ST_COUNT;
            tick_cnt_d = 4'd0;
            soft_cnt_d = 23'd0;
            drop_req_d = 1'b0;
          end else begin
            if (tick_due_s) begin
              tick_cnt_d = 4'd0;
            end else if (tick_in) begin
              tick_cnt_d = tick_next_s[3:0];
            end else begin
              tick_cnt_d = tick_cnt_q;
            end
            if (!soft_drop || soft_due_s) begin
              soft_cnt_d = 23'd0;
            end else begin
              soft_cnt_d = soft_cnt_q + 23'd1;
            end
            if (state_q == ST_COUNT) begin
              if (due_s) begin
                state_d    = ST_REQ;
                drop_req_d = 1'b1;
              end else begin
                state_d    = ST_COUNT;
                drop_req_d = 1'b0;
              end
            end else begin
              if (drop_ack && !due_s) begin
                state_d    = ST_COUNT;
                drop_req_d = 1'b0;
              end else if (due_s) begin
                // ack+due re-arms the request; due alone is lost
                state_d    = ST_REQ;
                drop_req_d = 1'b1;
                overrun_d  = ~drop_ack;
              end else begin
                state_d    = ST_REQ;
                drop_req_d = 1'b1;
              end
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          tick_cnt_d = 4'd0;
          soft_cnt_d = 23'd0;
          drop_req_d = 1'b0;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= 4'd0;
      soft_cnt_q <= 23'd0;
      drop_req_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      soft_cnt_q <= soft_cnt_d;
      drop_req_q <= drop_req_d;
      overrun_q  <= overrun_d;
    end
  end

  assign drop_req = drop_req_q;
  assign overrun  = overrun_q;

endmodule
